rv_biu: RTL

//  Bus interface unit between the RV core and the single shared memory bus.

---
 rtl/rv_biu.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv_biu.sv
// Bus interface unit: arbitrates fetch and load/store requests onto one shared memory bus,
// one outstanding transaction at a time, with byte-lane steering and an ack timeout.
module rv_biu #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter bit          ARB_RR  = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          fetch_valid_i,
    output logic          fetch_ready_o,
    input  logic [AW-1:0] fetch_addr_i,
    output logic [31:0]   instr_word_o,
    output logic          instr_valid_o,
    output logic          instr_err_o,
    input  logic          dreq_valid_i,
    output logic          dreq_ready_o,
    input  logic          dreq_we_i,
    input  logic [1:0]    dreq_size_i,
    input  logic [AW-1:0] dreq_addr_i,
    input  logic [31:0]   dreq_wdata_i,
    output logic          drsp_valid_o,
    output logic [31:0]   drsp_rdata_o,
    output logic          drsp_err_o,
    output logic          ads_o,
    output logic          rd_wr_n_o,
    output logic          i_dn_o,
    output logic [AW-1:0] addr_o,
    output logic [3:0]    be_o,
    output logic [31:0]   wr_data_o,
    input  logic [31:0]   rd_data_i,
    input  logic          ack_i
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StCmd, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_data_q, last_data_d;
    logic          own_data_q, own_data_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   instr_word_q, instr_word_d;
    logic [31:0]   drsp_rdata_q, drsp_rdata_d;
    logic          rd_wr_n_q, rd_wr_n_d;
    logic          i_dn_q, i_dn_d;

    logic          gnt_data, gnt_fetch, accept, acc_err;
    logic          capture, timed_out;
    logic [1:0]    acc_size, acc_off;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata, rd_shift, load_data;

    // Round-robin favours whichever channel did not win the previous accept.
    assign gnt_data  = dreq_valid_i & (~fetch_valid_i | ~ARB_RR | ~last_data_q);
    assign gnt_fetch = fetch_valid_i & ~gnt_data;

    assign fetch_ready_o = (state_q == StIdle) & gnt_fetch;
    assign dreq_ready_o  = (state_q == StIdle) & gnt_data;
    assign accept        = fetch_ready_o | dreq_ready_o;

    // Fetches are treated as word accesses so alignment and lane logic is shared.
    assign acc_size = gnt_data ? dreq_size_i : 2'd2;
    assign acc_off  = gnt_data ? dreq_addr_i[1:0] : fetch_addr_i[1:0];

    always_comb begin
        acc_err   = 1'b0;
        acc_be    = 4'b1111;
        acc_wdata = dreq_wdata_i;
        unique case (acc_size)
            2'd0: begin
                acc_be    = 4'b0001 << acc_off;
                acc_wdata = {4{dreq_wdata_i[7:0]}};
            end
            2'd1: begin
                acc_err   = acc_off[0];
                acc_be    = 4'b0011 << acc_off;
                acc_wdata = {2{dreq_wdata_i[15:0]}};
            end
            2'd2:    acc_err = (acc_off != 2'd0);
            default: acc_err = 1'b1;
        endcase
    end

    assign rd_shift = rd_data_i >> {off_q, 3'b000};

    always_comb begin
        load_data = rd_shift;
        unique case (size_q)
            2'd0:    load_data = {24'd0, rd_shift[7:0]};
            2'd1:    load_data = {16'd0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_data_d  = last_data_q;
        own_data_d   = own_data_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        err_d        = err_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wr_data_d    = wr_data_q;
        instr_word_d = instr_word_q;
        drsp_rdata_d = drsp_rdata_q;
        rd_wr_n_d    = rd_wr_n_q;
        i_dn_d       = i_dn_q;
        capture      = 1'b0;
        timed_out    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_data_d = gnt_data;
                    own_data_d  = gnt_data;
                    we_d        = gnt_data & dreq_we_i;
                    size_d      = acc_size;
                    off_d       = acc_off;
                    cnt_d       = '0;
                    if (acc_err) begin
                        // Rejected request: no bus cycle, error response next cycle.
                        state_d = StResp;
                        err_d   = 1'b1;
                        if (gnt_data) drsp_rdata_d = '0;
                        else          instr_word_d = '0;
                    end else begin
                        state_d   = StCmd;
                        err_d     = 1'b0;
                        addr_d    = gnt_data ? dreq_addr_i : fetch_addr_i;
                        addr_d[1:0] = 2'b00;
                        be_d      = acc_be;
                        wr_data_d = acc_wdata;
                        rd_wr_n_d = ~(gnt_data & dreq_we_i);
                        i_dn_d    = ~gnt_data;
                    end
                end
            end
            StCmd: begin
                if (ack_i) begin
                    capture = 1'b1;
                end else begin
                    state_d = StWait;
                    cnt_d   = CW'(1);
                end
            end
            StWait: begin
                if (ack_i) begin
                    capture = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (capture) begin
            state_d = StResp;
            err_d   = 1'b0;
            if (own_data_q) drsp_rdata_d = we_q ? 32'd0 : load_data;
            else            instr_word_d = rd_data_i;
        end
        if (timed_out) begin
            state_d = StResp;
            err_d   = 1'b1;
            if (own_data_q) drsp_rdata_d = '0;
            else            instr_word_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_data_q  <= 1'b0;
            own_data_q   <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'd0;
            wr_data_q    <= '0;
            instr_word_q <= '0;
            drsp_rdata_q <= '0;
            rd_wr_n_q    <= 1'b1;
            i_dn_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_data_q  <= last_data_d;
            own_data_q   <= own_data_d;
            we_q         <= we_d;
            size_q       <= size_d;
            off_q        <= off_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wr_data_q    <= wr_data_d;
            instr_word_q <= instr_word_d;
            drsp_rdata_q <= drsp_rdata_d;
            rd_wr_n_q    <= rd_wr_n_d;
            i_dn_q       <= i_dn_d;
        end
    end

    assign ads_o         = (state_q == StCmd);
    assign instr_valid_o = (state_q == StResp) & ~own_data_q;
    assign instr_err_o   = instr_valid_o & err_q;
    assign drsp_valid_o  = (state_q == StResp) & own_data_q;
    assign drsp_err_o    = drsp_valid_o & err_q;
    assign instr_word_o  = instr_word_q;
    assign drsp_rdata_o  = drsp_rdata_q;
    assign rd_wr_n_o     = rd_wr_n_q;
    assign i_dn_o        = i_dn_q;
    assign addr_o        = addr_q;
    assign be_o          = be_q;
    assign wr_data_o     = wr_data_q;

endmodule
